// File: rtl/peridot_uart_pkg.sv
// ---------------------------------------------------------------------------
// peridot_uart_pkg : shared constants, FSM encodings and divider helper for the PERIDOT UART PHYs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package peridot_uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int         OS_RATE     = 16;
  localparam logic [3:0] SAMPLE_POS0 = 4'd7;
  localparam logic [3:0] SAMPLE_POS1 = 4'd8;
  localparam logic [3:0] SAMPLE_POS2 = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic int os_div_calc(input int clk_hz, input int baud);
    int div;
    div = clk_hz / (baud * OS_RATE) - 1;
    if (div < 0) div = 0;
    return div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/peridot_uart_baudgen.sv
// ---------------------------------------------------------------------------
// peridot_uart_baudgen : 16x oversample tick generator with synchronous clear
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module peridot_uart_baudgen
  import peridot_uart_pkg::*;
#(
  parameter int DIV = 0
) (
  input  logic clock_sig,
  input  logic reset_sig,
  input  logic clear,
  output logic tick
);

  localparam int            CW    = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_W = CW'(DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The clearing cycle itself is a tick, so the next one lands DIV+1 clocks later.
  always_comb begin
    tick  = clear || (cnt_q == DIV_W);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/peridot_uart_rx_ext.sv
// ---------------------------------------------------------------------------
// peridot_uart_rx_ext : UART receiver PHY, 16x oversampling, majority vote, ready/valid output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module peridot_uart_rx_ext
  import peridot_uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int UART_BAUDRATE   = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int SYNC_STAGES     = 3
) (
  input  logic                 clock_sig,
  input  logic                 reset_sig,
  input  logic                 rxd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [1:0]           out_error,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int         OS_DIV     = os_div_calc(CLOCK_FREQUENCY, UART_BAUDRATE);
  localparam int         HAS_PAR    = (PARITY_MODE != PAR_NONE) ? 1 : 0;
  localparam logic [3:0] DATA_IDX   = 4'(DATA_BITS);
  localparam logic [3:0] FIRST_STOP = 4'(DATA_BITS + HAS_PAR + 1);
  localparam logic [3:0] LAST_IDX   = 4'(DATA_BITS + HAS_PAR + STOP_BITS);

  rx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [3:0]             osc_q, osc_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_bit_q, par_bit_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;
  logic                   complete_q, complete_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0]   out_data_q, out_data_d;
  logic [1:0]             out_error_q, out_error_d;
  logic                   overrun_q, overrun_d;
  logic                   break_det_q, break_det_d;

  logic rx_s;
  logic rx_fall;
  logic bit_val;
  logic perr;
  logic baud_clr;
  logic baud_tick;
  logic brk_now;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign rx_fall  = rx_prev_q && !rx_s;
  assign baud_clr = (state_q == ST_IDLE) && rx_fall;
  assign bit_val  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign perr     = (HAS_PAR != 0) &&
                    ((^shreg_q ^ par_bit_q) != (PARITY_MODE == PAR_ODD));

  peridot_uart_baudgen #(
    .DIV (OS_DIV)
  ) u_baudgen (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .clear     (baud_clr),
    .tick      (baud_tick)
  );

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rxd};
    rx_prev_d   = rx_s;
    state_d     = state_q;
    osc_d       = osc_q;
    bit_idx_d   = bit_idx_q;
    smp_d       = smp_q;
    shreg_d     = shreg_q;
    par_bit_d   = par_bit_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;
    brk_now     = brk_q;
    complete_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_error_d = out_error_q;
    overrun_d   = 1'b0;
    break_det_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Detection cycle is oversample tick 0, so counting resumes at 1.
        if (rx_fall) begin
          state_d   = ST_START;
          osc_d     = 4'd1;
          bit_idx_d = 4'd0;
          shreg_d   = '0;
          par_bit_d = 1'b0;
          ferr_d    = 1'b0;
          brk_d     = 1'b0;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        if (baud_tick) begin
          osc_d = osc_q + 4'd1;
          if (osc_q == 4'd15)       bit_idx_d = bit_idx_q + 4'd1;
          if (osc_q == SAMPLE_POS0) smp_d[0]  = rx_s;
          if (osc_q == SAMPLE_POS1) smp_d[1]  = rx_s;
          if (osc_q == SAMPLE_POS2) begin
            case (state_q)
              ST_START: state_d = bit_val ? ST_IDLE : ST_DATA;
              ST_DATA: begin
                shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                if (bit_idx_q == DATA_IDX) state_d = (HAS_PAR != 0) ? ST_PARITY : ST_STOP;
              end
              ST_PARITY: begin
                par_bit_d = bit_val;
                state_d   = ST_STOP;
              end
              ST_STOP: begin
                if (!bit_val) ferr_d = 1'b1;
                if (bit_idx_q == FIRST_STOP) begin
                  brk_now = (shreg_q == '0) && !par_bit_q && !bit_val;
                  brk_d   = brk_now;
                end
                // Leaving at mid-bit lets the next start edge be seen half a bit early.
                if (bit_idx_q == LAST_IDX) begin
                  complete_d = 1'b1;
                  state_d    = brk_now ? ST_WAIT_IDLE : ST_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    if (complete_q) begin
      break_det_d = brk_q;
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = brk_q ? '0 : shreg_q;
        out_error_d = brk_q ? 2'b01 : {perr, ferr_q};
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q     <= ST_IDLE;
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      osc_q       <= 4'd0;
      bit_idx_q   <= 4'd0;
      smp_q       <= 2'b00;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
      complete_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_error_q <= 2'b00;
      overrun_q   <= 1'b0;
      break_det_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      osc_q       <= osc_d;
      bit_idx_q   <= bit_idx_d;
      smp_q       <= smp_d;
      shreg_q     <= shreg_d;
      par_bit_q   <= par_bit_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
      complete_q  <= complete_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_error_q <= out_error_d;
      overrun_q   <= overrun_d;
      break_det_q <= break_det_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_error = out_error_q;
  assign overrun   = overrun_q;
  assign break_det = break_det_q;

endmodule

`default_nettype wire
